arbitrate: RTL and testbench



---
 rtl/arbitrate.sv | 105 ++++++++++
 tb/tb_arbitrate.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arbitrate.sv
// Round-robin N-to-1 stream arbiter. Each accepted word is tagged {index, data}
// and passes through a two-entry registered output stage (output + skid register).
module arbitrate #(
  parameter  int W  = 8,
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_stb,
  input  logic [N*W-1:0]  s_dat,
  output logic [N-1:0]    s_rdy,
  input  logic            m_rdy,
  output logic            m_stb,
  output logic [IW+W-1:0] m_dat
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } stage_t;

  stage_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   grant;
  logic            found;
  logic [IW+W-1:0] skid_dat;
  logic [IW+W-1:0] in_word;
  logic            acc;
  logic            out;
  int              idx;

  // Search last+1, last+2, ... modulo N so the wrap is correct for any N.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && s_stb[idx]) begin
        found = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end

  // Accept depends only on registered state and s_stb, never on m_rdy.
  always_comb begin
    s_rdy = '0;
    if (found && (state != ST_FULL) && rst)
      s_rdy[grant] = 1'b1;
  end

  assign acc     = |(s_stb & s_rdy);
  assign out     = m_stb && m_rdy;
  assign in_word = {grant, s_dat[int'(grant)*W +: W]};

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      state    <= ST_EMPTY;
      m_stb    <= 1'b0;
      m_dat    <= '0;
      skid_dat <= '0;
      last     <= IW'(N - 1);
    end else begin
      if (acc)
        last <= grant;
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            m_dat <= in_word;
            m_stb <= 1'b1;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && out) begin
            m_dat <= in_word;
          end else if (acc) begin
            skid_dat <= in_word;
            state    <= ST_FULL;
          end else if (out) begin
            m_stb <= 1'b0;
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // The skid word is older than anything upstream, so it goes next.
          if (out) begin
            m_dat <= skid_dat;
            state <= ST_ONE;
          end
        end
        default: begin
          m_stb <= 1'b0;
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitrate.sv
// Directed bench for arbitrate: reset, backpressure, tagging, fairness, odd-N wrap,
// followed by a randomized run on N=3 checked against a small reference model.
module tb_arbitrate;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // N=2, W=8
  logic [1:0]  s2_stb, s2_rdy;
  logic [15:0] s2_dat;
  logic        m2_rdy, m2_stb;
  logic [8:0]  m2_dat;
  // N=3, W=8
  logic [2:0]  s3_stb, s3_rdy;
  logic [23:0] s3_dat;
  logic        m3_rdy, m3_stb;
  logic [9:0]  m3_dat;
  // N=4, W=8
  logic [3:0]  s4_stb, s4_rdy;
  logic [31:0] s4_dat;
  logic        m4_rdy, m4_stb;
  logic [9:0]  m4_dat;

  arbitrate #(.W(8), .N(2)) u2 (
    .clk(clk), .rst(rst), .s_stb(s2_stb), .s_dat(s2_dat), .s_rdy(s2_rdy),
    .m_rdy(m2_rdy), .m_stb(m2_stb), .m_dat(m2_dat)
  );
  arbitrate #(.W(8), .N(3)) u3 (
    .clk(clk), .rst(rst), .s_stb(s3_stb), .s_dat(s3_dat), .s_rdy(s3_rdy),
    .m_rdy(m3_rdy), .m_stb(m3_stb), .m_dat(m3_dat)
  );
  arbitrate #(.W(8), .N(4)) u4 (
    .clk(clk), .rst(rst), .s_stb(s4_stb), .s_dat(s4_dat), .s_rdy(s4_rdy),
    .m_rdy(m4_rdy), .m_stb(m4_stb), .m_dat(m4_dat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] fair_exp [9];
  logic [9:0] q [$];
  logic [2:0] erdy;
  int         mlast;
  int         g;
  int         idx;

  initial begin
    fair_exp = '{10'h0A0, 10'h1B1, 10'h2C2, 10'h0A0, 10'h1B1,
                 10'h2C2, 10'h0A0, 10'h1B1, 10'h2C2};

    rst    = 1'b0;
    s2_stb = 2'b11; s2_dat = 16'h4433; m2_rdy = 1'b1;
    s3_stb = 3'b000; s3_dat = 24'hC2B1A0; m3_rdy = 1'b1;
    s4_stb = 4'b0000; s4_dat = 32'hFFA5FFFF; m4_rdy = 1'b1;

    // Reset state, before and across clock edges
    #3;
    check("rst_rdy", 32'(s2_rdy), 32'h0);
    check("rst_stb", 32'(m2_stb), 32'h0);
    check("rst_dat", 32'(m2_dat), 32'h0);
    tick();
    tick();
    check("rst_rdy_clk", 32'(s2_rdy), 32'h0);
    check("rst_stb_clk", 32'(m2_stb), 32'h0);
    check("rst3_dat", 32'(m3_dat), 32'h0);

    // Release: input 0 has first priority
    rst = 1'b1;
    #1;
    check("first_grant", 32'(s2_rdy), 32'h1);
    tick();
    check("a_stb", 32'(m2_stb), 32'h1);
    check("a_dat", 32'(m2_dat), 32'h033);
    check("a_rdy", 32'(s2_rdy), 32'h2);

    // Backpressure: m_rdy low for three edges
    m2_rdy = 1'b0;
    #1;
    check("rdy_no_mrdy_path", 32'(s2_rdy), 32'h2);
    tick();
    check("b_dat_stable", 32'(m2_dat), 32'h033);
    check("b_stb", 32'(m2_stb), 32'h1);
    check("b_full_rdy", 32'(s2_rdy), 32'h0);
    tick();
    check("c_dat_stable", 32'(m2_dat), 32'h033);
    check("c_full_rdy", 32'(s2_rdy), 32'h0);
    tick();
    check("d_dat_stable", 32'(m2_dat), 32'h033);
    m2_rdy = 1'b1;
    tick();
    check("e_skid_out", 32'(m2_dat), 32'h144);
    check("e_rdy", 32'(s2_rdy), 32'h1);
    tick();
    check("f_dat", 32'(m2_dat), 32'h033);

    // Fill the stage, then reset asynchronously mid-stream
    m2_rdy = 1'b0;
    tick();
    check("g_full_rdy", 32'(s2_rdy), 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_stb", 32'(m2_stb), 32'h0);
    check("mid_rst_dat", 32'(m2_dat), 32'h0);
    check("mid_rst_rdy", 32'(s2_rdy), 32'h0);
    #1;
    rst    = 1'b1;
    m2_rdy = 1'b1;
    #1;
    check("post_rst_grant", 32'(s2_rdy), 32'h1);
    tick();
    check("post_rst_dat", 32'(m2_dat), 32'h033);
    s2_stb = 2'b00;

    // Tagging on N=4: only input 2 requests
    s4_stb = 4'b0100;
    #1;
    check("tag_rdy", 32'(s4_rdy), 32'h4);
    tick();
    s4_stb = 4'b0000;
    check("tag_stb", 32'(m4_stb), 32'h1);
    check("tag_dat", 32'(m4_dat), 32'h2A5);
    #1;
    check("idle_rdy", 32'(s4_rdy), 32'h0);

    // Fairness on N=3: all inputs requesting
    s3_stb = 3'b111;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("fair_%0d", i), 32'(m3_dat), 32'(fair_exp[i]));
    end

    // Non-power-of-two wrap: last=2, only inputs 0 and 2
    s3_stb = 3'b101;
    #1;
    check("wrap_g0", 32'(s3_rdy), 32'h1);
    tick();
    check("wrap_d0", 32'(m3_dat), 32'h0A0);
    check("wrap_g2", 32'(s3_rdy), 32'h4);
    tick();
    check("wrap_d2", 32'(m3_dat), 32'h2C2);
    check("wrap_g0b", 32'(s3_rdy), 32'h1);
    s3_stb = 3'b000;
    tick();
    check("drain_stb", 32'(m3_stb), 32'h0);
    check("drain_hold", 32'(m3_dat), 32'h2C2);

    // Random traffic on N=3 against a reference model
    mlast = 2;
    for (int n = 0; n < 3000; n++) begin
      s3_stb = 3'($urandom);
      s3_dat = 24'($urandom);
      m3_rdy = 1'($urandom);
      #1;
      g = -1;
      for (int k = 1; k <= 3; k++) begin
        idx = (mlast + k) % 3;
        if (g < 0 && s3_stb[idx]) g = idx;
      end
      erdy = (g >= 0 && q.size() < 2) ? 3'(1 << g) : 3'b000;
      check("rnd_rdy", 32'(s3_rdy), 32'(erdy));
      check("rnd_stb", 32'(m3_stb), 32'(q.size() != 0));
      if (q.size() != 0) check("rnd_dat", 32'(m3_dat), 32'(q[0]));
      if (q.size() != 0 && m3_rdy) void'(q.pop_front());
      if (erdy != 3'b000) begin
        q.push_back({2'(g), s3_dat[g*8 +: 8]});
        mlast = g;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
